// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt sequencer for the 5-stage pipeline.
// Selects one event per cycle (overflow > reserved instr > break/syscall >
// interrupt), spends one TAKE cycle writing EPC/Cause and vectoring fetch,
// runs the handler, and spends one RETURN cycle jumping back to EPC on ERET.
module exc_ctrl #(
  parameter logic [31:0] VECTOR_ADDR     = 32'h8000_0180,
  parameter int          INT_SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        ovf_ex,
  input  logic        ri_id,
  input  logic        brk_id,
  input  logic        eret_id,
  input  logic        ext_int,
  input  logic        int_en,
  input  logic [31:0] pc_id,
  input  logic [31:0] pc_ex,
  input  logic [31:0] epc_q,
  output logic        EPCWrite,
  output logic        CauseWrite,
  output logic [1:0]  IntCause,
  output logic [31:0] epc_d,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        flush_if,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        in_handler
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TAKE    = 2'd1,
    S_HANDLER = 2'd2,
    S_RETURN  = 2'd3
  } state_t;

  localparam logic [1:0] CODE_INT = 2'd0;
  localparam logic [1:0] CODE_BRK = 2'd1;
  localparam logic [1:0] CODE_RI  = 2'd2;
  localparam logic [1:0] CODE_OVF = 2'd3;

  state_t      r_state;
  // Synchronizer stages [INT_SYNC_STAGES-1:0] plus one extra flop at the top
  // holding the previous synchronized value for rising-edge detection.
  logic [INT_SYNC_STAGES:0] r_sync;
  logic        r_int_pending;

  logic        r_epc_write;
  logic        r_cause_write;
  logic [1:0]  r_int_cause;
  logic [31:0] r_epc_d;
  logic        r_pc_redirect;
  logic [31:0] r_pc_target;
  logic        r_flush_if;
  logic        r_flush_id;
  logic        r_flush_ex;
  logic        r_in_handler;

  logic        w_can_detect;
  logic        w_int_rise;
  logic        w_int_req;
  logic        w_evt;
  logic [1:0]  w_code;
  logic [31:0] w_pc;
  logic        w_take_int;

  // Events are only looked at while no TAKE/RETURN is in flight.
  assign w_can_detect = (r_state == S_IDLE) || (r_state == S_HANDLER);
  // The edge that is about to set int_pending already counts as a request.
  assign w_int_rise   = r_sync[INT_SYNC_STAGES-1] & ~r_sync[INT_SYNC_STAGES];
  assign w_int_req    = (r_int_pending | w_int_rise) & int_en & (r_state == S_IDLE);

  // Priority event selector: code and PC to capture for the winning event.
  always_comb begin
    w_evt  = 1'b0;
    w_code = CODE_INT;
    w_pc   = pc_id;
    if (w_can_detect) begin
      if (ovf_ex) begin
        w_evt  = 1'b1;
        w_code = CODE_OVF;
        w_pc   = pc_ex;
      end else if (ri_id) begin
        w_evt  = 1'b1;
        w_code = CODE_RI;
      end else if (brk_id) begin
        w_evt  = 1'b1;
        w_code = CODE_BRK;
      end else if (w_int_req) begin
        w_evt  = 1'b1;
        w_code = CODE_INT;
      end
    end
  end

  assign w_take_int = w_evt & (w_code == CODE_INT);

  // Shift the external interrupt line through the synchronizer chain.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[INT_SYNC_STAGES-1:0], ext_int};
    end
  end

  // Latch synchronized rising edges until the interrupt is actually taken.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_int_pending <= 1'b0;
    end else if (w_take_int) begin
      r_int_pending <= 1'b0;
    end else if (w_int_rise) begin
      r_int_pending <= 1'b1;
    end
  end

  // Sequencer FSM with registered strobes; strobes default low every cycle.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_epc_write   <= 1'b0;
      r_cause_write <= 1'b0;
      r_int_cause   <= 2'd0;
      r_epc_d       <= 32'h0;
      r_pc_redirect <= 1'b0;
      r_pc_target   <= 32'h0;
      r_flush_if    <= 1'b0;
      r_flush_id    <= 1'b0;
      r_flush_ex    <= 1'b0;
      r_in_handler  <= 1'b0;
    end else begin
      r_epc_write   <= 1'b0;
      r_cause_write <= 1'b0;
      r_pc_redirect <= 1'b0;
      r_pc_target   <= 32'h0;
      r_flush_if    <= 1'b0;
      r_flush_id    <= 1'b0;
      r_flush_ex    <= 1'b0;
      case (r_state)
        S_IDLE, S_HANDLER: begin
          if (w_evt) begin
            // An exception beats a same-cycle ERET; EPC is simply overwritten.
            r_state       <= S_TAKE;
            r_int_cause   <= w_code;
            r_epc_d       <= w_pc;
            r_epc_write   <= 1'b1;
            r_cause_write <= 1'b1;
            r_pc_redirect <= 1'b1;
            r_pc_target   <= VECTOR_ADDR;
            r_flush_if    <= 1'b1;
            r_flush_id    <= 1'b1;
            r_flush_ex    <= (w_code == CODE_OVF);
          end else if ((r_state == S_HANDLER) && eret_id) begin
            r_state       <= S_RETURN;
            r_pc_redirect <= 1'b1;
            r_pc_target   <= epc_q;
            r_flush_if    <= 1'b1;
            r_flush_id    <= 1'b1;
          end
        end
        S_TAKE: begin
          r_state      <= S_HANDLER;
          r_in_handler <= 1'b1;
        end
        S_RETURN: begin
          r_state      <= S_IDLE;
          r_in_handler <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign EPCWrite    = r_epc_write;
  assign CauseWrite  = r_cause_write;
  assign IntCause    = r_int_cause;
  assign epc_d       = r_epc_d;
  assign pc_redirect = r_pc_redirect;
  assign pc_target   = r_pc_target;
  assign flush_if    = r_flush_if;
  assign flush_id    = r_flush_id;
  // The overflowing instruction is squashed in its own detection cycle, so
  // its writeback never reaches the register file.
  assign flush_ex    = r_flush_ex | (rst_n & w_can_detect & ovf_ex);
  assign in_handler  = r_in_handler;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed stimulus for exc_ctrl, checked every cycle against a
// behavioural model plus literal expectations at the key points.
module tb_exc_ctrl;

  localparam int          NS  = 2;
  localparam logic [31:0] VEC = 32'h8000_0180;

  localparam int M_QUIET   = 0;
  localparam int M_VECTOR  = 1;
  localparam int M_HANDLER = 2;
  localparam int M_RETURN  = 3;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        ovf_ex, ri_id, brk_id, eret_id, ext_int, int_en;
  logic [31:0] pc_id, pc_ex, epc_q;
  logic        EPCWrite, CauseWrite;
  logic [1:0]  IntCause;
  logic [31:0] epc_d;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        flush_if, flush_id, flush_ex, in_handler;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  exc_ctrl #(.VECTOR_ADDR(VEC), .INT_SYNC_STAGES(NS)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .ovf_ex(ovf_ex), .ri_id(ri_id), .brk_id(brk_id), .eret_id(eret_id),
    .ext_int(ext_int), .int_en(int_en),
    .pc_id(pc_id), .pc_ex(pc_ex), .epc_q(epc_q),
    .EPCWrite(EPCWrite), .CauseWrite(CauseWrite), .IntCause(IntCause),
    .epc_d(epc_d), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex),
    .in_handler(in_handler)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_mode;
  logic        m_active;
  logic [1:0]  m_cause;
  logic [31:0] m_epc;
  logic [31:0] m_ret;
  logic        m_pend;
  logic        m_hist[$];   // ext_int as sampled at past edges, newest first
  logic        m_rise;
  logic        m_ev;
  logic [1:0]  m_c;
  logic [31:0] m_p;

  task automatic model_reset();
    m_mode   = M_QUIET;
    m_active = 1'b0;
    m_cause  = 2'd0;
    m_epc    = 32'h0;
    m_ret    = 32'h0;
    m_pend   = 1'b0;
    m_hist   = {};
    for (int i = 0; i <= NS; i++) m_hist.push_back(1'b0);
  endtask

  // The interrupt counts as arriving once an edge has travelled NS samples.
  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_rise = m_hist[NS-1] && !m_hist[NS];
      m_ev = 1'b0; m_c = 2'd0; m_p = pc_id;
      if (m_mode == M_QUIET || m_mode == M_HANDLER) begin
        if (ovf_ex)      begin m_ev = 1'b1; m_c = 2'd3; m_p = pc_ex; end
        else if (ri_id)  begin m_ev = 1'b1; m_c = 2'd2; end
        else if (brk_id) begin m_ev = 1'b1; m_c = 2'd1; end
        else if (m_mode == M_QUIET && int_en && (m_pend || m_rise)) begin
          m_ev = 1'b1; m_c = 2'd0;
        end
      end
      if (m_ev && m_c == 2'd0) m_pend = 1'b0;
      else if (m_rise)         m_pend = 1'b1;
      if (m_ev) begin
        m_mode = M_VECTOR; m_cause = m_c; m_epc = m_p;
      end else if (m_mode == M_HANDLER && eret_id) begin
        m_mode = M_RETURN; m_ret = epc_q;
      end else if (m_mode == M_VECTOR) begin
        m_mode = M_HANDLER; m_active = 1'b1;
      end else if (m_mode == M_RETURN) begin
        m_mode = M_QUIET; m_active = 1'b0;
      end
      m_hist.push_front(ext_int);
      void'(m_hist.pop_back());
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    logic vec, ret, det;
    vec = (m_mode == M_VECTOR);
    ret = (m_mode == M_RETURN);
    det = (m_mode == M_QUIET || m_mode == M_HANDLER);
    chk("m_EPCWrite",    EPCWrite,    vec);
    chk("m_CauseWrite",  CauseWrite,  vec);
    chk("m_IntCause",    IntCause,    m_cause);
    chk("m_epc_d",       epc_d,       m_epc);
    chk("m_pc_redirect", pc_redirect, vec | ret);
    chk("m_pc_target",   pc_target,   vec ? VEC : (ret ? m_ret : 32'h0));
    chk("m_flush_if",    flush_if,    vec | ret);
    chk("m_flush_id",    flush_id,    vec | ret);
    chk("m_flush_ex",    flush_ex,    (vec && m_cause == 2'd3) || (rst_n && det && ovf_ex));
    chk("m_in_handler",  in_handler,  m_active);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ovf_ex = 0; ri_id = 0; brk_id = 0; eret_id = 0;
    ext_int = 0; int_en = 0; pc_id = 0; pc_ex = 0; epc_q = 0;
    repeat (2) @(negedge CLK);
    chk("rst_EPCWrite", EPCWrite, 0);
    chk("rst_in_handler", in_handler, 0);
    chk("rst_pc_target", pc_target, 0);
    @(posedge CLK); #1 rst_n = 1'b1;
    tick();

    // overflow in IDLE
    pc_ex = 32'h0040_0010; ovf_ex = 1;
    @(negedge CLK);
    chk("A_det_flush_ex", flush_ex, 1);
    chk("A_det_EPCWrite", EPCWrite, 0);
    tick(); ovf_ex = 0;
    @(negedge CLK);
    chk("A_EPCWrite", EPCWrite, 1);
    chk("A_CauseWrite", CauseWrite, 1);
    chk("A_IntCause", IntCause, 3);
    chk("A_epc_d", epc_d, 32'h0040_0010);
    chk("A_pc_target", pc_target, 32'h8000_0180);
    chk("A_flush_ex", flush_ex, 1);
    tick();
    @(negedge CLK);
    chk("A_in_handler", in_handler, 1);

    // overflow + reserved together, then reserved alone (nested)
    pc_ex = 32'h0040_0030; pc_id = 32'h0040_0034; ovf_ex = 1; ri_id = 1;
    tick(); ovf_ex = 0; ri_id = 0;
    @(negedge CLK);
    chk("B_IntCause", IntCause, 3);
    chk("B_epc_d", epc_d, 32'h0040_0030);
    tick();
    pc_id = 32'h0040_0020; ri_id = 1;
    tick(); ri_id = 0;
    @(negedge CLK);
    chk("B_ri_IntCause", IntCause, 2);
    chk("B_ri_epc_d", epc_d, 32'h0040_0020);
    chk("B_ri_flush_ex", flush_ex, 0);
    tick();
    epc_q = 32'h0040_0040; eret_id = 1;
    tick(); eret_id = 0;
    @(negedge CLK);
    chk("B_ret_redirect", pc_redirect, 1);
    chk("B_ret_target", pc_target, 32'h0040_0040);
    tick();
    @(negedge CLK);
    chk("B_idle_in_handler", in_handler, 0);

    // interrupt with int_en=1: TAKE three edges after ext_int rises
    int_en = 1; pc_id = 32'h0040_0050; ext_int = 1;
    tick(); tick();
    @(negedge CLK);
    chk("C_early_EPCWrite", EPCWrite, 0);
    tick(); ext_int = 0;
    @(negedge CLK);
    chk("C_EPCWrite", EPCWrite, 1);
    chk("C_IntCause", IntCause, 0);
    chk("C_epc_d", epc_d, 32'h0040_0050);
    tick();
    epc_q = 32'h0040_0054; eret_id = 1;
    tick(); eret_id = 0;
    tick();

    // interrupt with int_en=0 stays pending until enabled
    int_en = 0; ext_int = 1;
    repeat (3) tick();
    ext_int = 0;
    repeat (3) tick();
    @(negedge CLK);
    chk("D_masked_in_handler", in_handler, 0);
    chk("D_masked_EPCWrite", EPCWrite, 0);
    int_en = 1; pc_id = 32'h0040_0070;
    tick();
    @(negedge CLK);
    chk("D_EPCWrite", EPCWrite, 1);
    chk("D_IntCause", IntCause, 0);
    chk("D_epc_d", epc_d, 32'h0040_0070);
    tick();

    // interrupt arriving in HANDLER waits for ERET, then is taken
    ext_int = 1;
    repeat (3) tick();
    ext_int = 0;
    @(negedge CLK);
    chk("E_masked_EPCWrite", EPCWrite, 0);
    epc_q = 32'h0040_0024; eret_id = 1;
    tick(); eret_id = 0;
    @(negedge CLK);
    chk("E_ret_redirect", pc_redirect, 1);
    chk("E_ret_target", pc_target, 32'h0040_0024);
    chk("E_ret_CauseWrite", CauseWrite, 0);
    pc_id = 32'h0040_0028;
    tick();
    @(negedge CLK);
    chk("E_idle_in_handler", in_handler, 0);
    chk("E_idle_redirect", pc_redirect, 0);
    tick();
    @(negedge CLK);
    chk("E_int_EPCWrite", EPCWrite, 1);
    chk("E_int_IntCause", IntCause, 0);
    chk("E_int_epc_d", epc_d, 32'h0040_0028);
    tick();

    // ERET and BREAK together in HANDLER: exception wins
    pc_id = 32'h0040_0060; eret_id = 1; brk_id = 1;
    tick(); eret_id = 0; brk_id = 0;
    @(negedge CLK);
    chk("F_IntCause", IntCause, 1);
    chk("F_pc_target", pc_target, 32'h8000_0180);
    chk("F_EPCWrite", EPCWrite, 1);
    tick();
    @(negedge CLK);
    chk("F_in_handler", in_handler, 1);
    epc_q = 32'h0040_0064; eret_id = 1;
    tick(); eret_id = 0;
    tick();

    // ERET in IDLE is ignored
    eret_id = 1;
    tick(); eret_id = 0;
    @(negedge CLK);
    chk("G_idle_eret_redirect", pc_redirect, 0);
    chk("G_idle_eret_in_handler", in_handler, 0);

    // overflow held two cycles: the copy seen during TAKE is ignored
    pc_ex = 32'h0040_0080; ovf_ex = 1;
    tick(); pc_ex = 32'h0040_0084;
    tick(); ovf_ex = 0;
    @(negedge CLK);
    chk("H_epc_d", epc_d, 32'h0040_0080);
    chk("H_EPCWrite", EPCWrite, 0);
    chk("H_in_handler", in_handler, 1);
    eret_id = 1;
    tick(); eret_id = 0;
    tick();

    // asynchronous reset during TAKE
    pc_ex = 32'h0040_0090; ovf_ex = 1;
    tick(); ovf_ex = 0;
    #2;
    chk("I_pre_EPCWrite", EPCWrite, 1);
    rst_n = 1'b0;
    #1;
    chk("I_rst_EPCWrite", EPCWrite, 0);
    chk("I_rst_redirect", pc_redirect, 0);
    chk("I_rst_flush_if", flush_if, 0);
    @(posedge CLK); #1 rst_n = 1'b1;
    @(negedge CLK);
    chk("I_post_in_handler", in_handler, 0);
    chk("I_post_EPCWrite", EPCWrite, 0);
    tick();
    @(negedge CLK);
    chk("I_idle_in_handler", in_handler, 0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
